// File: rtl/misc_v_pkg.sv
// Shared MISC-V pipeline definitions: forwarding encodings, controller states,
// stage-record layouts and the producer-match rule used by all hazard logic.
package misc_v_pkg;

  localparam int TAG_W = 3;

  localparam logic [1:0] FWD_MEM  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_REG  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;
  localparam logic       FWD3_WB  = 1'b0;
  localparam logic       FWD3_REG = 1'b1;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_MEMWAIT} ctrlState_e;
  typedef enum logic [1:0] {ACT_ADVANCE, ACT_FLUSH, ACT_STALL, ACT_FREEZE} pipeAction_e;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] rd;
    logic             rw;
    logic             mr;
    logic             mw;
    logic [TAG_W-1:0] rs1;
    logic [TAG_W-1:0] rs2;
    logic [TAG_W-1:0] rs3;
    logic             use1;
    logic             use2;
    logic             use3;
  } exRec_t;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] rd;
    logic             rw;
    logic             mr;
  } memRec_t;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] rd;
    logic             rw;
  } wbRec_t;

  // r0 is hardwired zero, so it never has a producer worth forwarding.
  function automatic logic producerHit(input logic v, input logic rw,
                                       input logic [TAG_W-1:0] rd,
                                       input logic [TAG_W-1:0] tag);
    return v && rw && (rd == tag) && (tag != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one EX source tag against the MEM and WB records and returns the
// forwarding select; WB_ONLY restricts the choice to WB data or register file.
module fwd_match
  import misc_v_pkg::*;
#(
  parameter int REG_AW  = TAG_W,
  parameter bit WB_ONLY = 1'b0
) (
  input  logic [REG_AW-1:0] tag,
  input  logic              memV,
  input  logic [REG_AW-1:0] memRd,
  input  logic              memRw,
  input  logic              memMr,
  input  logic              wbV,
  input  logic [REG_AW-1:0] wbRd,
  input  logic              wbRw,
  output logic [1:0]        sel,
  output logic              memLoadHit
);

  logic memHit;
  logic wbHit;

  assign memHit     = producerHit(memV, memRw, memRd, tag);
  assign wbHit      = producerHit(wbV, wbRw, wbRd, tag);
  assign memLoadHit = memHit && memMr;

  // A load in MEM has no data yet, so it falls through to WB/register file.
  always_comb begin
    sel = FWD_REG;
    if (!WB_ONLY && memHit && !memMr) sel = FWD_MEM;
    else if (wbHit)                   sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the MISC-V five-stage core: tracks EX/MEM/WB
// register tags, drives EX forwarding selects and stage advance/squash controls.
module hazard_fwd_ctrl
  import misc_v_pkg::*;
#(
  parameter int REG_AW = TAG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rs3,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_use3,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic [1:0]        fwd1_sel,
  output logic [1:0]        fwd2_sel,
  output logic              fwd3_sel,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cycles
);

  ctrlState_e  state;
  pipeAction_e action;
  exRec_t      exRec;
  exRec_t      idRec;
  memRec_t     memRec;
  wbRec_t      wbRec;
  logic [CNT_W-1:0] stallCnt;

  logic [1:0] sel1, sel2, sel3;
  logic       loadHit1, loadHit2, loadHit3;
  logic       exHit1, exHit2, exHit3;
  logic       hazard;

  assign idRec = '{v: id_valid, rd: id_rd, rw: id_reg_write, mr: id_mem_read,
                   mw: id_mem_write, rs1: id_rs1, rs2: id_rs2, rs3: id_rs3,
                   use1: id_use1, use2: id_use2, use3: id_use3};

  fwd_match #(.REG_AW(REG_AW), .WB_ONLY(1'b0)) uFwd1 (
    .tag(exRec.rs1), .memV(memRec.v), .memRd(memRec.rd), .memRw(memRec.rw),
    .memMr(memRec.mr), .wbV(wbRec.v), .wbRd(wbRec.rd), .wbRw(wbRec.rw),
    .sel(sel1), .memLoadHit(loadHit1)
  );

  fwd_match #(.REG_AW(REG_AW), .WB_ONLY(1'b0)) uFwd2 (
    .tag(exRec.rs2), .memV(memRec.v), .memRd(memRec.rd), .memRw(memRec.rw),
    .memMr(memRec.mr), .wbV(wbRec.v), .wbRd(wbRec.rd), .wbRw(wbRec.rw),
    .sel(sel2), .memLoadHit(loadHit2)
  );

  // Store data has no MEM bypass path, only WB or the register file.
  fwd_match #(.REG_AW(REG_AW), .WB_ONLY(1'b1)) uFwd3 (
    .tag(exRec.rs3), .memV(memRec.v), .memRd(memRec.rd), .memRw(memRec.rw),
    .memMr(memRec.mr), .wbV(wbRec.v), .wbRd(wbRec.rd), .wbRw(wbRec.rw),
    .sel(sel3), .memLoadHit(loadHit3)
  );

  assign exHit1 = producerHit(exRec.v, exRec.rw, exRec.rd, id_rs1);
  assign exHit2 = producerHit(exRec.v, exRec.rw, exRec.rd, id_rs2);
  assign exHit3 = producerHit(exRec.v, exRec.rw, exRec.rd, id_rs3);

  assign hazard = id_valid &&
                  ((exRec.mr && ((id_use1 && exHit1) || (id_use2 && exHit2) ||
                                 (id_use3 && exHit3))) ||
                   (id_mem_write && id_use3 && exHit3));

  // STALL re-evaluates as RUN; every state freezes while memory is busy.
  always_comb begin
    action = ACT_ADVANCE;
    if (mem_busy)             action = ACT_FREEZE;
    else if (ex_branch_taken) action = ACT_FLUSH;
    else if (hazard)          action = ACT_STALL;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      case (action)
        ACT_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        ACT_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        ACT_FREEZE: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign fwd1_sel     = reset ? sel1 : FWD_REG;
  assign fwd2_sel     = reset ? sel2 : FWD_REG;
  assign fwd3_sel     = (reset && exRec.mw && sel3 == FWD_WB) ? FWD3_WB : FWD3_REG;
  assign stall_cycles = stallCnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_RUN;
      exRec.v  <= 1'b0;
      memRec.v <= 1'b0;
      wbRec.v  <= 1'b0;
      stallCnt <= '0;
    end else begin
      case (action)
        ACT_FREEZE: state <= ST_MEMWAIT;
        ACT_STALL:  state <= ST_STALL;
        default:    state <= ST_RUN;
      endcase
      if (action != ACT_FREEZE) begin
        exRec  <= (action == ACT_ADVANCE) ? idRec : '0;
        memRec <= '{v: exRec.v, rd: exRec.rd, rw: exRec.rw, mr: exRec.mr};
        wbRec  <= '{v: memRec.v, rd: memRec.rd, rw: memRec.rw};
      end
      if (!pc_write && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  // A consumer in EX must never see its source still being loaded in MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(exRec.v && ((exRec.use1 && loadHit1) || (exRec.use2 && loadHit2) ||
                            (exRec.use3 && loadHit3))));
      assert (state != ST_STALL || !exRec.v);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use and store stalls,
// branch squash, memory freeze, counter saturation and mid-run reset.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_rs3, id_rd;
  logic       id_use1, id_use2, id_use3;
  logic       id_reg_write, id_mem_read, id_mem_write;
  logic       ex_branch_taken, mem_busy;
  logic [1:0] fwd1_sel, fwd2_sel;
  logic       fwd3_sel, pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  hazard_fwd_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .fwd3_sel(fwd3_sel), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v, rd, rs1, rs2, rs3, use1, use2, use3, regWrite, memRead, memWrite
  task automatic setId(input logic v, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [2:0] rs3,
                       input logic u1, input logic u2, input logic u3,
                       input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_rs3 = rs3;
    id_use1 = u1; id_use2 = u2; id_use3 = u3;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    #3;
  endtask

  task automatic nop();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; mem_busy = 1'b0; ex_branch_taken = 1'b0;
    nop();
    chk("rst_pc_write", 16'(pc_write), 16'd1);
    chk("rst_ifid_write", 16'(ifid_write), 16'd1);
    chk("rst_flush", 16'(ifid_flush), 16'd0);
    chk("rst_bubble", 16'(idex_bubble), 16'd0);
    chk("rst_fwd1", 16'(fwd1_sel), 16'd2);
    chk("rst_fwd2", 16'(fwd2_sel), 16'd2);
    chk("rst_fwd3", 16'(fwd3_sel), 16'd1);
    tick();
    chk("rst_count", stall_cycles, 16'd0);
    tick();
    reset = 1'b1;

    // Back-to-back ALU producer/consumer: MEM forward
    setId(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("alu_pc_write", 16'(pc_write), 16'd1);
    tick(); setId(1, 2, 1, 3, 0, 1, 1, 0, 1, 0, 0);
    chk("alu_no_stall", 16'(pc_write), 16'd1);
    tick(); nop();
    chk("fwd_mem", 16'(fwd1_sel), 16'd0);
    chk("fwd_mem_rs2_reg", 16'(fwd2_sel), 16'd2);

    // One NOP between: WB forward
    tick(); setId(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); nop();
    tick(); setId(1, 2, 1, 3, 0, 1, 1, 0, 1, 0, 0);
    tick(); nop();
    chk("fwd_wb", 16'(fwd1_sel), 16'd1);

    // r0 producer never forwards
    tick(); setId(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); setId(1, 2, 0, 3, 0, 1, 1, 0, 1, 0, 0);
    tick(); nop();
    chk("fwd_r0", 16'(fwd1_sel), 16'd2);

    // MEM and WB both match: MEM wins
    tick(); setId(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); setId(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); setId(1, 4, 1, 1, 0, 1, 1, 0, 1, 0, 0);
    tick(); nop();
    chk("fwd_prio1", 16'(fwd1_sel), 16'd0);
    chk("fwd_prio2", 16'(fwd2_sel), 16'd0);

    // Load-use: lw r2 ; add r4,r2,r2
    tick(); nop(); tick(); nop(); tick(); nop();
    tick(); setId(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick(); setId(1, 4, 2, 2, 0, 1, 1, 0, 1, 0, 0);
    chk("lu_pc_write", 16'(pc_write), 16'd0);
    chk("lu_ifid_write", 16'(ifid_write), 16'd0);
    chk("lu_bubble", 16'(idex_bubble), 16'd1);
    chk("lu_flush", 16'(ifid_flush), 16'd0);
    tick(); setId(1, 4, 2, 2, 0, 1, 1, 0, 1, 0, 0);
    chk("lu_resume", 16'(pc_write), 16'd1);
    chk("lu_no_bubble", 16'(idex_bubble), 16'd0);
    chk("lu_count", stall_cycles, 16'd1);
    tick(); nop();
    chk("lu_fwd1", 16'(fwd1_sel), 16'd1);
    chk("lu_fwd2", 16'(fwd2_sel), 16'd1);

    // Store data: addi r5 ; sw r5 -> (r6)
    tick(); nop(); tick(); nop(); tick(); nop();
    tick(); setId(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); setId(1, 0, 6, 0, 5, 1, 0, 1, 0, 0, 1);
    chk("st_pc_write", 16'(pc_write), 16'd0);
    chk("st_bubble", 16'(idex_bubble), 16'd1);
    tick(); setId(1, 0, 6, 0, 5, 1, 0, 1, 0, 0, 1);
    chk("st_resume", 16'(pc_write), 16'd1);
    chk("st_count", stall_cycles, 16'd2);
    tick(); nop();
    chk("st_fwd3", 16'(fwd3_sel), 16'd0);
    chk("st_fwd1", 16'(fwd1_sel), 16'd2);
    tick(); nop();
    chk("st_fwd3_idle", 16'(fwd3_sel), 16'd1);

    // Hazard together with taken branch: squash wins
    tick(); nop(); tick(); nop(); tick(); nop();
    tick(); setId(1, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick(); ex_branch_taken = 1'b1; setId(1, 4, 3, 0, 0, 1, 0, 0, 1, 0, 0);
    chk("br_flush", 16'(ifid_flush), 16'd1);
    chk("br_bubble", 16'(idex_bubble), 16'd1);
    chk("br_pc_write", 16'(pc_write), 16'd1);
    chk("br_ifid_write", 16'(ifid_write), 16'd1);
    tick(); ex_branch_taken = 1'b0; nop();
    chk("br_count", stall_cycles, 16'd2);

    // Load-use stall followed by three busy-memory cycles
    tick(); nop(); tick(); nop(); tick(); nop();
    tick(); setId(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick(); setId(1, 4, 2, 2, 0, 1, 1, 0, 1, 0, 0);
    chk("mw_stall", 16'(pc_write), 16'd0);
    tick(); mem_busy = 1'b1; setId(1, 4, 2, 2, 0, 1, 1, 0, 1, 0, 0);
    chk("mw_pc_write1", 16'(pc_write), 16'd0);
    chk("mw_ifid_write", 16'(ifid_write), 16'd0);
    chk("mw_bubble", 16'(idex_bubble), 16'd0);
    chk("mw_flush", 16'(ifid_flush), 16'd0);
    tick();
    chk("mw_pc_write2", 16'(pc_write), 16'd0);
    tick();
    chk("mw_pc_write3", 16'(pc_write), 16'd0);
    tick(); mem_busy = 1'b0; #1;
    chk("mw_release", 16'(pc_write), 16'd1);
    chk("mw_count", stall_cycles, 16'd6);
    tick(); nop();
    chk("mw_fwd1", 16'(fwd1_sel), 16'd1);
    chk("mw_fwd2", 16'(fwd2_sel), 16'd1);

    // Saturate the counter in MEMWAIT, then reset mid-freeze
    tick(); mem_busy = 1'b1; nop();
    repeat (65535) tick();
    chk("sat_count", stall_cycles, 16'hFFFF);
    chk("sat_frozen", 16'(pc_write), 16'd0);
    reset = 1'b0; #1;
    chk("rst_mid_pc_write", 16'(pc_write), 16'd1);
    chk("rst_mid_fwd1", 16'(fwd1_sel), 16'd2);
    tick(); reset = 1'b1; mem_busy = 1'b0; nop();
    chk("rst2_count", stall_cycles, 16'd0);
    chk("rst2_pc_write", 16'(pc_write), 16'd1);
    chk("rst2_ifid_write", 16'(ifid_write), 16'd1);
    chk("rst2_bubble", 16'(idex_bubble), 16'd0);
    chk("rst2_fwd1", 16'(fwd1_sel), 16'd2);
    chk("rst2_fwd2", 16'(fwd2_sel), 16'd2);
    chk("rst2_fwd3", 16'(fwd3_sel), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
